// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
//   Runtime-writable, multi-bank colour palette. A (bank, index) pair is
//   mapped to RGB through a 2-stage registered pipeline. The result carries
//   an opacity flag. A host port loads entries. A clear FSM zeroes every
//   entry after reset and again whenever clr_start_i is pulsed.
//
//   Optional feature macro: PALETTE_FLASH_EN
//     When defined, it adds flash_i. A flashed pixel is output as all-ones RGB.
//
// Ports
//   Clk, Reset_n                 clock, synchronous active-low reset
//   px_valid_i/bank_i/index_i    lookup request
//   px_valid_o, red/green/blue   lookup result, 2 cycles after request
//   px_opaque_o                  result index differs from TRANS_IDX
//   wr_en_i/bank_i/index_i/data_i  entry write, data packed {R,G,B}
//   clr_start_i, clr_busy_o      clear request / clear in progress
//   flash_i                      (PALETTE_FLASH_EN only) force white
module sprite_palette_bank #(
  parameter int CHAN_W    = 4,
  parameter int INDEX_W   = 4,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int TRANS_IDX = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  px_valid_i,
  input  logic [BANK_W-1:0]     px_bank_i,
  input  logic [INDEX_W-1:0]    px_index_i,
`ifdef PALETTE_FLASH_EN
  input  logic                  flash_i,
`endif
  output logic                  px_valid_o,
  output logic [CHAN_W-1:0]     red,
  output logic [CHAN_W-1:0]     green,
  output logic [CHAN_W-1:0]     blue,
  output logic                  px_opaque_o,
  input  logic                  wr_en_i,
  input  logic [BANK_W-1:0]     wr_bank_i,
  input  logic [INDEX_W-1:0]    wr_index_i,
  input  logic [3*CHAN_W-1:0]   wr_data_i,
  input  logic                  clr_start_i,
  output logic                  clr_busy_o
);

  localparam int RGB_W  = 3 * CHAN_W;
  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [RGB_W-1:0]  mem [DEPTH];

  logic              vld_p1;
  logic [BANK_W-1:0] bank_p1;
  logic [INDEX_W-1:0] idx_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_commit;
  logic [RGB_W-1:0]  rd_data;
  logic [RGB_W-1:0]  rgb_p2;
`ifdef PALETTE_FLASH_EN
  logic              flash_p1;
`endif

  // Any entry read while the palette is being cleared is reported as black,
  // including entries that the sweep has not yet reached.
  function automatic logic [RGB_W-1:0] colour_out(input logic [RGB_W-1:0] entry,
                                                   input logic clearing);
    return clearing ? '0 : entry;
  endfunction

  assign wr_addr   = {wr_bank_i, wr_index_i};
  assign addr_p1   = {bank_p1, idx_p1};
  assign wr_commit = wr_en_i && !clr_busy_o;
  // Write-first: a write that lands on the address S2 is reading wins.
  assign rd_data   = (wr_commit && (wr_addr == addr_p1)) ? wr_data_i : mem[addr_p1];

  // Clear FSM. clr_busy_o is a registered mirror of state == ST_CLEAR.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      clr_busy_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start_i) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            clr_busy_o <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CNT_W'(DEPTH - 1)) begin
            state      <= ST_IDLE;
            clr_busy_o <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_CLEAR;
          clr_cnt    <= '0;
          clr_busy_o <= 1'b1;
        end
      endcase
    end
  end

  // Palette storage. The clear sweep owns the port while busy, so host writes are dropped.
  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      if (clr_busy_o)
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      else if (wr_en_i)
        mem[wr_addr] <= wr_data_i;
    end
  end

  // ---- stage 1: capture request ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p1 <= 1'b0;
`ifdef PALETTE_FLASH_EN
      flash_p1 <= 1'b0;
`endif
    end else begin
      vld_p1 <= px_valid_i;
`ifdef PALETTE_FLASH_EN
      flash_p1 <= flash_i;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    bank_p1 <= px_bank_i;
    idx_p1  <= px_index_i;
  end

  // ---- stage 2: palette read, colour registered ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      px_valid_o  <= 1'b0;
      px_opaque_o <= 1'b0;
      rgb_p2      <= '0;
    end else begin
      px_valid_o  <= vld_p1;
      px_opaque_o <= vld_p1 && (idx_p1 != INDEX_W'(TRANS_IDX));
      if (vld_p1) begin
`ifdef PALETTE_FLASH_EN
        rgb_p2 <= flash_p1 ? '1 : colour_out(rd_data, clr_busy_o);
`else
        rgb_p2 <= colour_out(rd_data, clr_busy_o);
`endif
      end
    end
  end

  assign {red, green, blue} = rgb_p2;

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-bank colour palette for the sprite/tile renderers. Replaces fixed constant palettes.
- Maps a per-pixel (bank, index) pair to RGB through a 2-stage registered pipeline, with a transparency flag.
- Has a host write port for loading entries and a self-clearing FSM that runs after reset and on request.
- Sits between the sprite ROM index fetch and the VGA colour mux.

Parameters:
- CHAN_W, 4: bits per colour channel.
- INDEX_W, 4: colour index width. Entries per bank = 2**INDEX_W.
- NUM_BANKS, 4: number of palettes. Must be a power of two, >= 2.
- BANK_W, $clog2(NUM_BANKS): bank select width (derived).
- TRANS_IDX, 0: index value treated as transparent.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- px_valid_i  in  1  lookup request valid.
- px_bank_i  in  BANK_W  palette bank for the lookup.
- px_index_i  in  INDEX_W  colour index for the lookup.
- px_valid_o  out  1  lookup result valid.
- red  out  CHAN_W  result red.
- green  out  CHAN_W  result green.
- blue  out  CHAN_W  result blue.
- px_opaque_o  out  1  result is non-transparent.
- wr_en_i  in  1  entry write strobe.
- wr_bank_i  in  BANK_W  write bank.
- wr_index_i  in  INDEX_W  write index.
- wr_data_i  in  3*CHAN_W  packed {R,G,B}, R in the MSBs.
- clr_start_i  in  1  pulse: clear all entries.
- clr_busy_o  out  1  clear in progress.

Behaviour:
- Storage: NUM_BANKS*2**INDEX_W entries of 3*CHAN_W bits. Address = {bank, index}. DEPTH = total entry count (64 at defaults).
- Lookup pipeline, fixed latency 2 cycles, no stalls, one lookup accepted per cycle:
  - S1 registers px_valid_i, bank, index.
  - S2 reads the entry at the S1 address, registers RGB, and drives px_valid_o.
- Colour outputs hold their last value when px_valid_o = 0.
- px_opaque_o = px_valid_o && (S1 index != TRANS_IDX), registered alongside RGB. The palette colour is still output for transparent pixels.
- Host write: commits at the edge where wr_en_i = 1, provided clr_busy_o = 0. While clr_busy_o = 1, wr_en_i is ignored (write dropped).
- Read/write collision: if a write commits on the same edge S2 loads the same address, S2 outputs wr_data_i (write-first bypass).
- Clear FSM, states CLEAR and IDLE:
  - CLEAR: writes 0 to address clr_cnt, then increments clr_cnt. After writing address DEPTH-1, goes to IDLE.
  - IDLE: clr_start_i = 1 moves to CLEAR with clr_cnt = 0. clr_start_i is ignored while in CLEAR.
  - clr_busy_o = 1 exactly while in CLEAR.
- Clear timing: CLEAR lasts DEPTH cycles; clr_busy_o falls the cycle after the last clear write.
- Lookups during CLEAR still flow with 2-cycle latency, but RGB is forced to 0. px_opaque_o follows the index rule.
- Reset (Reset_n = 0 at an edge):
  - State = CLEAR, clr_cnt = 0, clr_busy_o = 1.
  - S1/S2 valid = 0, px_valid_o = 0, px_opaque_o = 0, red = green = blue = 0.
  - The auto-clear begins on the first edge with Reset_n = 1.
- Reset mid-clear restarts clearing from address 0. Reset mid-lookup discards in-flight pixels.
- Bank/index widths are exact. No wrap logic is needed; clr_cnt is $clog2(DEPTH)+1 bits wide so the terminal compare is unambiguous.

Optional Feature:
- Macro: PALETTE_FLASH_EN.
- When defined:
  - Adds input port flash_i (1 bit), captured in S1 with the pixel.
  - When the S1 flash bit is 1, S2 outputs all-ones RGB instead of the palette colour. px_opaque_o is unaffected.
  - Flash overrides the CLEAR zero-forcing.
  - The S1 flash register resets to 0.
- When undefined: no flash_i port and no flash logic. Behaviour is exactly as above.

Test Plan:
- Auto-clear: release reset, hold px_valid_i = 1 with bank 2, index 5.
  - Expect clr_busy_o = 1 for 64 cycles, then 0.
  - Expect px_valid_o = 1 from 2 cycles after release, RGB = 000.
  - Expect writes issued during busy to be dropped (readback = 000).
- Write/readback: after clear, write bank1/idx3 = 0xF42 and bank3/idx3 = 0x1A9.
  - Lookup bank1/idx3 then bank3/idx3 on consecutive cycles.
  - Expect 0xF42 then 0x1A9, 2 cycles after each request. Bank isolation confirmed.
- Transparency: write bank0/idx0 = 0xCCC, lookup bank0/idx0.
  - Expect RGB = C,C,C with px_opaque_o = 0.
  - Lookup idx1: expect px_opaque_o = 1.
- Collision bypass: entry bank2/idx7 = 0x123.
  - Issue lookup bank2/idx7 at cycle N and write 0xABC to bank2/idx7 at cycle N+1.
  - Expect output 0xABC at N+2.
  - A lookup at cycle N+1 also returns 0xABC.
- Mid-clear reset: pulse clr_start_i, wait 20 cycles, assert Reset_n = 0 for 1 cycle.
  - Expect clr_busy_o high for a further full 64 cycles after release.
  - Expect all outputs 0 during reset.
- Flash (with PALETTE_FLASH_EN): entry 0x421, lookup with flash_i = 1 at index 2.
  - Expect RGB = F,F,F and px_opaque_o = 1.
  - Next lookup with flash_i = 0: expect 0x421.
